pc_sequencer: RTL

Program-counter controller for the single-cycle CPU. It owns the PC register and sequences instruction fetch against a handshaked instruction memory. On each retire it selects the next PC from PC+4, the branch target (PC+4 plus sign-extended, pre-shifted offset), the jump target or the register-jump target. It sits between instruction memory and the decode/execute datapath, and is the only block that writes the PC.

---
 rtl/pc_seq_pkg.sv | 24 ++
 rtl/npc_calc.sv | 50 +++++
 rtl/pc_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the program-counter sequencer.
//   state_e          - sequencer FSM states (S_HALT only with PC_ALIGN_CHECK_EN)
//   RESET_PC_DEFAULT - default reset vector
//   INST_STEP        - byte distance between sequential instructions
// Optional feature macro: PC_ALIGN_CHECK_EN.
package pc_seq_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned IDX_W = 26;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] INST_STEP        = 32'd4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2
`ifdef PC_ALIGN_CHECK_EN
    ,
    S_HALT  = 2'd3
`endif
  } state_e;

endpackage

// File: rtl/npc_calc.sv
// npc_calc: combinational next-PC selection.
//   pc_plus_4                         - sequential successor of the current pc
//   branch_taken/branch_offset        - relative branch (offset pre-shifted)
//   jump_en/jump_index                - region jump within pc_plus_4[31:28]
//   jr_en/jr_target                   - register jump
//   next_pc_c                         - selected target (jr > jump > branch > pc+4)
//   misalign_c                        - target low bits non-zero (PC_ALIGN_CHECK_EN only)
// Optional feature macro: PC_ALIGN_CHECK_EN.
module npc_calc
  import pc_seq_pkg::*;
(
  input  logic [XLEN-1:0]  pc_plus_4,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_offset,
  input  logic             jump_en,
  input  logic [IDX_W-1:0] jump_index,
  input  logic             jr_en,
  input  logic [XLEN-1:0]  jr_target,
  output logic [XLEN-1:0]  next_pc_c
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             misalign_c
`endif
);

  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] jump_tgt;
  logic [XLEN-1:0] sel;

  // Branch wraps modulo 2^32; jump stays inside the 256 MB region of pc+4.
  assign branch_tgt = pc_plus_4 + branch_offset;
  assign jump_tgt   = {pc_plus_4[31:28], jump_index, 2'b00};

  // Priority select.
  always_comb begin
    sel = pc_plus_4;
    if (jr_en)             sel = jr_target;
    else if (jump_en)      sel = jump_tgt;
    else if (branch_taken) sel = branch_tgt;
  end

`ifdef PC_ALIGN_CHECK_EN
  assign next_pc_c  = sel;
  assign misalign_c = |sel[1:0];
`else
  // Without the check, targets are silently word-aligned.
  assign next_pc_c = sel & ~32'h0000_0003;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC and sequences fetch/retire against a handshaked imem.
//   clk, rst_n                 - clock, async active-low reset
//   imem_req/imem_addr         - fetch request, address (= pc)
//   imem_ack/imem_rdata        - fetch response
//   inst_valid/inst            - instruction awaiting retire
//   pc, pc_plus_4              - current pc, pc+4 (combinational)
//   retire + redirect inputs   - retire strobe, branch/jump/jr selection
//   inst_count                 - retired-instruction counter (wraps)
//   pc_err                     - sticky misaligned-target flag
// Optional feature macro: PC_ALIGN_CHECK_EN (misaligned target halts the sequencer).
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic             inst_valid,
  output logic [XLEN-1:0]  inst,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus_4,
  input  logic             retire,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_offset,
  input  logic             jump_en,
  input  logic [IDX_W-1:0] jump_index,
  input  logic             jr_en,
  input  logic [XLEN-1:0]  jr_target,
  output logic [XLEN-1:0]  inst_count,
  output logic             pc_err
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] inst_q, inst_d;
  logic [XLEN-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] next_pc;
`ifdef PC_ALIGN_CHECK_EN
  logic            misalign;
  logic            err_q, err_d;
`endif

  assign pc_plus_4 = pc_q + INST_STEP;

  npc_calc u_npc_calc (
    .pc_plus_4     (pc_plus_4),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_en       (jump_en),
    .jump_index    (jump_index),
    .jr_en         (jr_en),
    .jr_target     (jr_target),
    .next_pc_c     (next_pc)
`ifdef PC_ALIGN_CHECK_EN
    ,
    .misalign_c    (misalign)
`endif
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      valid_q <= valid_d;
`ifdef PC_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state and register updates; req/valid are decoded from the next state
  // so they are registered yet aligned with the state they describe.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    err_d   = err_q;
`endif
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          inst_d  = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (retire) begin
          cnt_d = cnt_q + 32'd1;
`ifdef PC_ALIGN_CHECK_EN
          if (misalign) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = next_pc;
            state_d = S_FETCH;
          end
`else
          pc_d    = next_pc;
          state_d = S_FETCH;
`endif
        end
      end
`ifdef PC_ALIGN_CHECK_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
    req_d   = (state_d == S_FETCH);
    valid_d = (state_d == S_EXEC);
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst_valid = valid_q;
  assign inst       = inst_q;
  assign pc         = pc_q;
  assign inst_count = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
  assign pc_err     = err_q;
`else
  assign pc_err     = 1'b0;
`endif

endmodule
